// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step generator.
//   - state_t : decoder FSM encoding (ST_INIT / ST_TRACK)
//   - AB_*    : filtered {A,B} Gray-code levels
//   - next_up : forward (count-up) neighbour of a Gray level
package quad_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  // Up sequence: 00 -> 01 -> 11 -> 10 -> 00 (A lags B going up).
  function automatic logic [1:0] next_up(input logic [1:0] ab);
    case (ab)
      AB_00:   next_up = AB_01;
      AB_01:   next_up = AB_11;
      AB_11:   next_up = AB_10;
      default: next_up = AB_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One quadrature channel: SYNC_STAGES-flop synchroniser followed by a
// stability filter. The filtered level only follows the synchronised level
// after it has differed for FILT_CNT consecutive cycles.
// Parameters:
//   SYNC_STAGES : synchroniser depth (2..4)
//   FILT_CNT    : stable cycles needed to accept a new level (1..15)
// Ports:
//   clk       : clock
//   rst       : asynchronous reset, active-high
//   raw_i     : raw channel input, asynchronous to clk
//   filt_o    : filtered level
//   busy_o    : filter counter nonzero (a change is pending)
//   settled_o : no change in flight anywhere in the synchroniser or filter
import quad_pkg::*;

module quad_chan_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o,
  output logic busy_o,
  output logic settled_o
);

  localparam int              CW       = 4;
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Counter runs while the levels disagree and clears the moment they agree,
  // so a pulse shorter than FILT_CNT cycles can never be accepted.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_lvl != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o    = filt_q;
  assign busy_o    = (cnt_q != '0);
  // Also covers levels still travelling through the synchroniser, which the
  // counter cannot see yet.
  assign settled_o = (cnt_q == '0) && (sync_q == {SYNC_STAGES{filt_q}});

endmodule

// File: rtl/quad_step_gen.sv
// Quadrature A/B to up/down-counter step converter.
// Synchronises and glitch-filters both channels, decodes Gray transitions and
// emits a one-cycle step strobe with its direction.
// Build option:
//   QUAD_STEP_X4_EN defined   : x4 decode, every legal transition is a step
//   QUAD_STEP_X4_EN undefined : x1 decode, only 10->00 (up) / 00->10 (down)
// Parameters:
//   SYNC_STAGES : synchroniser depth per channel (2..4)
//   FILT_CNT    : stable cycles needed before a channel changes (1..15)
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : asynchronous reset, active-high
//   a_in     : raw channel A
//   b_in     : raw channel B
//   en       : one-cycle step strobe
//   up_dwn_n : step direction (1 = up), held between steps
//   err      : one-cycle pulse on an illegal double transition
//   busy     : either channel has a change pending
module quad_step_gen
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  output logic en,
  output logic up_dwn_n,
  output logic err,
  output logic busy
);

  localparam logic [3:0] INIT_LAST = 4'(FILT_CNT - 1);

  logic       filt_a, filt_b;
  logic       busy_a, busy_b;
  logic       settled_a, settled_b;
  logic [1:0] cur_ab;
  logic [1:0] changed;

  state_t     state_q, state_d;
  logic [1:0] prev_q, prev_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic       en_q, en_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CNT    (FILT_CNT)
  ) u_filt_a (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (a_in),
    .filt_o    (filt_a),
    .busy_o    (busy_a),
    .settled_o (settled_a)
  );

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CNT    (FILT_CNT)
  ) u_filt_b (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (b_in),
    .filt_o    (filt_b),
    .busy_o    (busy_b),
    .settled_o (settled_b)
  );

  assign cur_ab  = {filt_a, filt_b};
  assign changed = cur_ab ^ prev_q;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    init_cnt_d = init_cnt_q;
    en_d       = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    case (state_q)
      // Wait for the inputs to settle so the level present at reset is
      // adopted as the reference instead of being decoded as a step.
      ST_INIT: begin
        if (!(settled_a && settled_b)) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          prev_d     = cur_ab;
          state_d    = ST_TRACK;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end
      ST_TRACK: begin
        // Reference always follows, so an illegal jump resynchronises.
        prev_d = cur_ab;
        if (changed == 2'b11) begin
          err_d = 1'b1;
        end else if (changed != 2'b00) begin
`ifdef QUAD_STEP_X4_EN
          en_d  = 1'b1;
          dir_d = (cur_ab == next_up(prev_q));
`else
          if ((prev_q == AB_10) && (cur_ab == AB_00)) begin
            en_d  = 1'b1;
            dir_d = 1'b1;
          end else if ((prev_q == AB_00) && (cur_ab == AB_10)) begin
            en_d  = 1'b1;
            dir_d = 1'b0;
          end
`endif
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      prev_q     <= AB_00;
      init_cnt_q <= '0;
      en_q       <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      init_cnt_q <= init_cnt_d;
      en_q       <= en_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign en       = en_q;
  assign up_dwn_n = dir_q;
  assign err      = err_q;
  assign busy     = busy_a | busy_b;

endmodule
